// File: rtl/conv_layer_sched.sv
// rtl/conv_layer_sched.sv - CONV pipeline job sequencer with shared result-memory port mux
// Runs conv k0/k1, pool k0/k1, flatten in order; owns watchdog, sticky errors, job cycle count.
module conv_layer_sched #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 20,
  parameter int WDOG_W  = 17,
  parameter int TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  output logic              cv_start,
  output logic              pl_start,
  output logic              fl_start,
  input  logic              cv_done,
  input  logic              pl_done,
  input  logic              fl_done,
  output logic              kidx,
  input  logic              cv_wr,
  input  logic [ADDR_W-1:0] cv_waddr,
  input  logic [DATA_W-1:0] cv_wdata,
  input  logic              pl_rd,
  input  logic              pl_wr,
  input  logic              pl_dst,
  input  logic [ADDR_W-1:0] pl_raddr,
  input  logic [ADDR_W-1:0] pl_waddr,
  input  logic [DATA_W-1:0] pl_wdata,
  input  logic              fl_rd,
  input  logic              fl_wr,
  input  logic [1:0]        fl_sel,
  input  logic [ADDR_W-1:0] fl_raddr,
  input  logic [ADDR_W-1:0] fl_waddr,
  input  logic [DATA_W-1:0] fl_wdata,
  output logic              crd,
  output logic              cwr,
  output logic [2:0]        csel,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [DATA_W-1:0] cdata_wr,
  output logic [2:0]        err,
  output logic [31:0]       cyc_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_CV0, S_CV1, S_PL0, S_PL1, S_FL, S_DONE} state_t;

  localparam logic [WDOG_W-1:0] WD_LAST = WDOG_W'(TIMEOUT - 1);

  state_t            state, state_nx, succ;
  logic [WDOG_W-1:0] wdog;
  logic              in_phase, first, live, start_job;
  logic              done_sel, wd_hit, rd_req, wr_req, conflict, illegal;
  logic [2:0]        sel;
  logic [ADDR_W-1:0] raddr, waddr;
  logic [DATA_W-1:0] wdata;

  // The watchdog doubles as the in-state age: zero marks the start cycle.
  assign in_phase  = (state inside {S_CV0, S_CV1, S_PL0, S_PL1, S_FL});
  assign first     = in_phase && (wdog == '0);
  assign live      = in_phase && !first;
  assign start_job = (state == S_IDLE) && ready && !busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      wdog    <= '0;
      busy    <= 1'b0;
      err     <= 3'b000;
      cyc_cnt <= 32'd0;
    end else begin
      state <= state_nx;
      if (state_nx != state || !in_phase) wdog <= '0;
      else                                wdog <= wdog + WDOG_W'(1);
      if (start_job) begin
        busy    <= 1'b1;
        err     <= 3'b000;
        cyc_cnt <= 32'd0;
      end else begin
        if (state_nx == S_DONE) busy <= 1'b0;
        err <= err | {illegal, conflict, wd_hit};
        if (busy && cyc_cnt != '1) cyc_cnt <= cyc_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    succ     = S_IDLE;
    cv_start = 1'b0;
    pl_start = 1'b0;
    fl_start = 1'b0;
    kidx     = 1'b0;
    done_sel = 1'b0;
    wd_hit   = 1'b0;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    illegal  = 1'b0;
    sel      = 3'b000;
    raddr    = '0;
    waddr    = '0;
    wdata    = '0;
    case (state)
      S_IDLE: if (start_job) state_nx = S_CV0;
      S_CV0, S_CV1: begin
        kidx     = (state == S_CV1);
        succ     = (state == S_CV0) ? S_CV1 : S_PL0;
        cv_start = first;
        done_sel = cv_done;
        if (live) begin
          wr_req = cv_wr;
          sel    = kidx ? 3'b010 : 3'b001;
          waddr  = cv_waddr;
          wdata  = cv_wdata;
        end
      end
      S_PL0, S_PL1: begin
        kidx     = (state == S_PL1);
        succ     = (state == S_PL0) ? S_PL1 : S_FL;
        pl_start = first;
        done_sel = pl_done;
        if (live) begin
          rd_req = pl_rd;
          wr_req = pl_wr;
          sel    = pl_dst ? (kidx ? 3'b100 : 3'b011) : (kidx ? 3'b010 : 3'b001);
          raddr  = pl_raddr;
          waddr  = pl_waddr;
          wdata  = pl_wdata;
        end
      end
      S_FL: begin
        succ     = S_DONE;
        fl_start = first;
        done_sel = fl_done;
        if (live) begin
          if (fl_sel == 2'd3) begin
            illegal = fl_rd || fl_wr;
          end else begin
            rd_req = fl_rd;
            wr_req = fl_wr;
            sel    = 3'd3 + {1'b0, fl_sel};
            raddr  = fl_raddr;
            waddr  = fl_waddr;
            wdata  = fl_wdata;
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // A late done wins over a watchdog expiry in the same cycle.
    if (live && done_sel) begin
      state_nx = succ;
    end else if (in_phase && wdog == WD_LAST) begin
      state_nx = S_DONE;
      wd_hit   = 1'b1;
    end
  end

  // Write has priority; a simultaneous read is dropped and flagged.
  assign conflict = rd_req && wr_req;
  assign cwr      = wr_req;
  assign crd      = rd_req && !wr_req;
  assign csel     = (crd || cwr) ? sel : 3'b000;
  assign caddr_rd = crd ? raddr : '0;
  assign caddr_wr = cwr ? waddr : '0;
  assign cdata_wr = cwr ? wdata : '0;

endmodule
